uart_wb_host: RTL

//  Bus initiator for the MiniUART register slave: moves bytes between a local push/strobe interface and the

---
 rtl/uart_wb_host.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_wb_host.sv
// Bus initiator for the MiniUART register slave: polls LSR, drains a small TX FIFO into DATA,
// captures received bytes and programs the divisors, all over an ACK-less single-cycle bus.
module uart_wb_host #(
  parameter int FIFO_AW  = 2,
  parameter int TX_GUARD = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [1:0]  ADD_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        STB_O,
  output logic        WE_O,
  input  logic [7:0]  tx_byte,
  input  logic        tx_push,
  output logic        tx_full,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic [15:0] div_rcv,
  input  logic [15:0] div_snd,
  input  logic        div_load,
  output logic        div_busy
);

  // state | meaning: IDLE no access | POLL read LSR | RXRD read DATA | RXCLR dummy LSR write (clears rs)
  //       | TXWR write FIFO head to DATA | DIVR write RX divisor | DIVT write TX divisor
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POLL  = 3'd1;
  localparam logic [2:0] S_RXRD  = 3'd2;
  localparam logic [2:0] S_RXCLR = 3'd3;
  localparam logic [2:0] S_TXWR  = 3'd4;
  localparam logic [2:0] S_DIVR  = 3'd5;
  localparam logic [2:0] S_DIVT  = 3'd6;

  localparam int GW = (TX_GUARD > 1) ? $clog2(TX_GUARD + 1) : 1;
  localparam logic [GW-1:0]      GUARD_INIT = GW'(TX_GUARD);
  localparam logic [GW-1:0]      GUARD_ONE  = GW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT   = {1'b1, {FIFO_AW{1'b0}}};

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [7:0]         r_mem [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [FIFO_AW:0]   w_count_next;
  logic [GW-1:0]      r_guard;
  logic [15:0]        r_div_rcv;
  logic [15:0]        r_div_snd;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;

  assign w_push  = tx_push & ~tx_full;
  assign w_pop   = (r_state == S_TXWR);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_ONE;
  end

  // RX is checked before TX so an arriving byte is never overwritten while we transmit.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = div_busy ? S_DIVR : S_POLL;
      S_POLL: begin
        if (DAT_I[0])
          w_next = S_RXRD;
        else if (DAT_I[5] && !w_empty && (r_guard == '0))
          w_next = S_TXWR;
        else
          w_next = S_IDLE;
      end
      S_RXRD: w_next = S_RXCLR;
      S_DIVR: w_next = S_DIVT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    STB_O = (r_state != S_IDLE);
    WE_O  = 1'b0;
    ADD_O = 2'd0;
    DAT_O = 32'd0;
    case (r_state)
      S_POLL:  ADD_O = 2'd1;
      S_RXCLR: begin WE_O = 1'b1; ADD_O = 2'd1; end
      S_TXWR:  begin WE_O = 1'b1; DAT_O = {24'd0, r_mem[r_rd_ptr]}; end
      S_DIVR:  begin WE_O = 1'b1; ADD_O = 2'd2; DAT_O = {16'd0, r_div_rcv}; end
      S_DIVT:  begin WE_O = 1'b1; ADD_O = 2'd3; DAT_O = {16'd0, r_div_snd}; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (w_push)
      r_mem[r_wr_ptr] <= tx_byte;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      tx_full   <= 1'b0;
      r_guard   <= '0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      div_busy  <= 1'b0;
      r_div_rcv <= 16'd0;
      r_div_snd <= 16'd0;
    end else begin
      r_state  <= w_next;
      rx_valid <= (r_state == S_RXRD);
      if (r_state == S_RXRD)
        rx_byte <= DAT_I[7:0];

      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      tx_full <= (w_count_next == FULL_CNT);

      if (r_state == S_TXWR)
        r_guard <= GUARD_INIT;
      else if (r_guard != '0)
        r_guard <= r_guard - GUARD_ONE;

      if (r_state == S_DIVT)
        div_busy <= 1'b0;
      else if (div_load && !div_busy) begin
        div_busy  <= 1'b1;
        r_div_rcv <= div_rcv;
        r_div_snd <= div_snd;
      end
    end
  end

endmodule
